display_read_sequencer: RTL and testbench

Read-side controller for the camera-to-VGA path, in the 25 MHz pixel clock domain. It sequences reads from the asynchronous pixel FIFO against the VGA timing core's pixel coordinates. It holds off display through camera startup, aligns the first read to a frame start, and detects and recovers from FIFO underflow. Sobel mode and threshold change only on frame boundaries, so the downstream pixel formatter never switches mid-frame.

---
 rtl/display_read_sequencer.sv | 171 +++++++++++++++++
 tb/tb_display_read_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_read_sequencer.sv
// display_read_sequencer: FIFO read sequencing for the camera-to-VGA path.
// Startup hold-off, frame-aligned arming, underflow recovery, frame-latched mode.
module display_read_sequencer #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int STARTUP_FRAMES  = 2,
    parameter int UNDERFLOW_LIMIT = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk_out,
    input  logic             rst_n,
    input  logic [11:0]      pixel_x,
    input  logic [11:0]      pixel_y,
    input  logic             empty_fifo,
    input  logic             sobel_req,
    input  logic [7:0]       threshold_req,
    input  logic             clr_stats,
    output logic             rd_en,
    output logic             pix_valid,
    output logic             sobel_mode,
    output logic [7:0]       threshold_q,
    output logic [CNT_W-1:0] underflow_cnt,
    output logic             underflow_sticky,
    output logic [1:0]       state_o
);

    localparam int FC_RAW = $clog2(STARTUP_FRAMES + 1);
    localparam int FC_W   = (FC_RAW > 0) ? FC_RAW : 1;
    localparam int RC_RAW = $clog2(UNDERFLOW_LIMIT + 1);
    localparam int RC_W   = (RC_RAW > 0) ? RC_RAW : 1;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_ARM     = 2'd1,
        ST_STREAM  = 2'd2,
        ST_RESYNC  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [RC_W-1:0]  run_cnt_q, run_cnt_d;
    logic             sobel_mode_q, sobel_mode_d;
    logic [7:0]       threshold_d;
    logic [CNT_W-1:0] underflow_cnt_q, underflow_cnt_d;
    logic             underflow_sticky_q, underflow_sticky_d;

    logic visible;
    logic sof;
    logic vbs;
    logic underflow;

    assign visible = (pixel_x < 12'(H_ACTIVE)) && (pixel_y < 12'(V_ACTIVE));
    assign sof     = (pixel_x == 12'd0) && (pixel_y == 12'd0);
    assign vbs     = (pixel_x == 12'd0) && (pixel_y == 12'(V_ACTIVE));

    // Sequencer: next state, frame/run counters and the read strobe.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        run_cnt_d   = run_cnt_q;
        rd_en       = 1'b0;
        pix_valid   = 1'b0;
        underflow   = 1'b0;
        unique case (state_q)
            ST_STARTUP: begin
                run_cnt_d = '0;
                if (STARTUP_FRAMES == 0) begin
                    state_d     = ST_ARM;
                    frame_cnt_d = '0;
                end else if (sof) begin
                    if (frame_cnt_q == FC_W'(STARTUP_FRAMES - 1)) begin
                        state_d     = ST_ARM;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            ST_ARM: begin
                run_cnt_d   = '0;
                frame_cnt_d = '0;
                if (sof && !empty_fifo) begin
                    rd_en     = 1'b1;
                    pix_valid = 1'b1;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                frame_cnt_d = '0;
                rd_en       = visible && !empty_fifo;
                pix_valid   = visible && !empty_fifo;
                underflow   = visible && empty_fifo;
                if (sof) begin
                    run_cnt_d = underflow ? RC_W'(1) : '0;
                end else if (underflow) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end else if (rd_en) begin
                    run_cnt_d = '0;
                end
                if (run_cnt_d == RC_W'(UNDERFLOW_LIMIT)) begin
                    state_d = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                frame_cnt_d = '0;
                run_cnt_d   = '0;
                rd_en       = !empty_fifo && !vbs;
                if (vbs) begin
                    state_d = ST_ARM;
                end
            end
            default: begin
                state_d     = ST_STARTUP;
                frame_cnt_d = '0;
                run_cnt_d   = '0;
            end
        endcase
    end

    // Mode and threshold only move at frame start so the formatter never splits a frame.
    always_comb begin
        sobel_mode_d = sobel_mode_q;
        threshold_d  = threshold_q;
        if (sof) begin
            sobel_mode_d = sobel_req;
            threshold_d  = threshold_req;
        end
    end

    // Underflow statistics; a clear beats a coincident underflow.
    always_comb begin
        underflow_cnt_d    = underflow_cnt_q;
        underflow_sticky_d = underflow_sticky_q;
        if (clr_stats) begin
            underflow_cnt_d    = '0;
            underflow_sticky_d = 1'b0;
        end else if (underflow) begin
            underflow_sticky_d = 1'b1;
            if (underflow_cnt_q != {CNT_W{1'b1}}) begin
                underflow_cnt_d = underflow_cnt_q + 1'b1;
            end
        end
    end

    // State and status registers.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= ST_STARTUP;
            frame_cnt_q        <= '0;
            run_cnt_q          <= '0;
            sobel_mode_q       <= 1'b0;
            threshold_q        <= 8'd0;
            underflow_cnt_q    <= '0;
            underflow_sticky_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            frame_cnt_q        <= frame_cnt_d;
            run_cnt_q          <= run_cnt_d;
            sobel_mode_q       <= sobel_mode_d;
            threshold_q        <= threshold_d;
            underflow_cnt_q    <= underflow_cnt_d;
            underflow_sticky_q <= underflow_sticky_d;
        end
    end

    assign sobel_mode       = sobel_mode_q;
    assign underflow_cnt    = underflow_cnt_q;
    assign underflow_sticky = underflow_sticky_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_display_read_sequencer.sv
// tb_display_read_sequencer: scoreboarded directed test on a shrunken raster.
// Expected read coordinates are queued by the stimulus; a monitor pops on rd_en.
module tb_display_read_sequencer;

    localparam int HA    = 8;
    localparam int VA    = 4;
    localparam int H_TOT = 10;
    localparam int V_TOT = 6;
    localparam int NPIX  = H_TOT * V_TOT;

    logic        clk_out = 1'b0;
    logic        rst_n;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        empty_fifo;
    logic        sobel_req;
    logic [7:0]  threshold_req;
    logic        clr_stats;
    logic        rd_en;
    logic        pix_valid;
    logic        sobel_mode;
    logic [7:0]  thr_o;
    logic [1:0]  underflow_cnt;
    logic        underflow_sticky;
    logic [1:0]  state_o;

    typedef struct {
        int x;
        int y;
        bit pv;
    } rd_t;

    rd_t exp_q[$];
    bit  emp_mask[NPIX];
    int  px;
    int  py;
    int  checks = 0;
    int  errors = 0;

    display_read_sequencer #(
        .H_ACTIVE(HA),
        .V_ACTIVE(VA),
        .STARTUP_FRAMES(2),
        .UNDERFLOW_LIMIT(4),
        .CNT_W(2)
    ) dut (
        .clk_out(clk_out),
        .rst_n(rst_n),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .empty_fifo(empty_fifo),
        .sobel_req(sobel_req),
        .threshold_req(threshold_req),
        .clr_stats(clr_stats),
        .rd_en(rd_en),
        .pix_valid(pix_valid),
        .sobel_mode(sobel_mode),
        .threshold_q(thr_o),
        .underflow_cnt(underflow_cnt),
        .underflow_sticky(underflow_sticky),
        .state_o(state_o)
    );

    always #5 clk_out = ~clk_out;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        #1;
        clr_stats = 1'b0;
        if (px == H_TOT - 1) begin
            px = 0;
            py = (py == V_TOT - 1) ? 0 : py + 1;
        end else begin
            px = px + 1;
        end
        pixel_x    = 12'(px);
        pixel_y    = 12'(py);
        empty_fifo = emp_mask[py * H_TOT + px];
    endtask

    task automatic run_to(input int x, input int y);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(px == x && py == y) && n < 2 * NPIX);
        if (!(px == x && py == y)) begin
            checks++;
            errors++;
            $display("FAIL run_to got (%0d,%0d) expected (%0d,%0d)",
                     px, py, x, y);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_mask();
        foreach (emp_mask[i]) emp_mask[i] = 1'b0;
    endtask

    task automatic push_frame(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if ((i % H_TOT) < HA && (i / H_TOT) < VA && !emp_mask[i])
                exp_q.push_back('{x: i % H_TOT, y: i / H_TOT, pv: 1'b1});
        end
    endtask

    task automatic push_drain(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (!emp_mask[i] && !((i % H_TOT) == 0 && (i / H_TOT) == VA))
                exp_q.push_back('{x: i % H_TOT, y: i / H_TOT, pv: 1'b0});
        end
    endtask

    // Monitor: every read strobe must match the next queued coordinate.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk_out);
            if (rd_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rd at (%0d,%0d) got rd_en=1 expected 0",
                             pixel_x, pixel_y);
                end else begin
                    e = exp_q.pop_front();
                    if (e.x != int'(pixel_x) || e.y != int'(pixel_y) ||
                        e.pv != pix_valid) begin
                        errors++;
                        $display("FAIL rd_match got (%0d,%0d,pv=%0d) expected (%0d,%0d,pv=%0d)",
                                 pixel_x, pixel_y, pix_valid, e.x, e.y, e.pv);
                    end
                end
            end else if (pix_valid) begin
                checks++;
                errors++;
                $display("FAIL pv_no_rd at (%0d,%0d) got pix_valid=1 expected 0",
                         pixel_x, pixel_y);
            end
        end
    end

    initial begin
        clear_mask();
        rst_n         = 1'b0;
        px            = 0;
        py            = 5;
        pixel_x       = 12'd0;
        pixel_y       = 12'd5;
        empty_fifo    = 1'b0;
        sobel_req     = 1'b1;
        threshold_req = 8'h11;
        clr_stats     = 1'b0;
        #3;
        chk("rst_state", state_o, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_cnt", underflow_cnt, 0);
        chk("rst_sticky", underflow_sticky, 0);
        chk("rst_mode", sobel_mode, 0);
        chk("rst_thr", thr_o, 0);
        tick();
        tick();
        tick();
        rst_n = 1'b1;

        // first sof: mode latches on the edge ending it, still STARTUP
        run_to(0, 0);
        settle();
        chk("sof1_mode_old", sobel_mode, 0);
        tick();
        settle();
        chk("sof1_mode_new", sobel_mode, 1);
        chk("sof1_thr_new", thr_o, 8'h11);
        chk("sof1_state", state_o, 0);

        // second sof arms
        run_to(0, 0);
        settle();
        chk("sof2_state", state_o, 0);
        tick();
        settle();
        chk("arm_state", state_o, 1);

        // empty at the arming sof: stay armed a frame
        emp_mask[0] = 1'b1;
        run_to(0, 0);
        settle();
        chk("arm_empty_rd", rd_en, 0);
        tick();
        settle();
        chk("arm_hold_state", state_o, 1);
        clear_mask();

        // next sof with data: stream a full frame
        push_frame(0, NPIX - 1);
        run_to(0, 0);
        settle();
        chk("stream_first_rd", rd_en, 1);
        chk("stream_first_pv", pix_valid, 1);
        tick();
        settle();
        chk("stream_state", state_o, 2);
        run_to(H_TOT - 1, V_TOT - 1);
        settle();
        chk("frame_reads_left", exp_q.size(), 0);

        // three underflows, then data; mode request moves mid-frame
        emp_mask[11] = 1'b1;
        emp_mask[12] = 1'b1;
        emp_mask[13] = 1'b1;
        push_frame(0, NPIX - 1);
        run_to(3, 1);
        settle();
        chk("uf_cnt_2", underflow_cnt, 2);
        chk("uf_sticky", underflow_sticky, 1);
        run_to(5, 1);
        settle();
        chk("uf_cnt_3", underflow_cnt, 3);
        chk("uf3_state", state_o, 2);
        run_to(0, 2);
        sobel_req     = 1'b0;
        threshold_req = 8'hA5;
        run_to(0, 3);
        settle();
        chk("mid_mode_hold", sobel_mode, 1);
        chk("mid_thr_hold", thr_o, 8'h11);
        run_to(H_TOT - 1, V_TOT - 1);
        settle();
        chk("frame5_reads_left", exp_q.size(), 0);

        // clr vs coincident underflow, then five spaced underflows saturate
        clear_mask();
        emp_mask[11] = 1'b1;
        emp_mask[21] = 1'b1;
        emp_mask[23] = 1'b1;
        emp_mask[25] = 1'b1;
        emp_mask[27] = 1'b1;
        emp_mask[31] = 1'b1;
        push_frame(0, NPIX - 1);
        run_to(0, 0);
        settle();
        chk("sof6_mode_old", sobel_mode, 1);
        chk("sof6_thr_old", thr_o, 8'h11);
        tick();
        settle();
        chk("sof6_mode_new", sobel_mode, 0);
        chk("sof6_thr_new", thr_o, 8'hA5);
        run_to(1, 1);
        clr_stats = 1'b1;
        settle();
        chk("pre_clr_cnt", underflow_cnt, 3);
        tick();
        settle();
        chk("clr_cnt", underflow_cnt, 0);
        chk("clr_sticky", underflow_sticky, 0);
        run_to(3, 3);
        settle();
        chk("sat_cnt", underflow_cnt, 3);
        chk("sat_sticky", underflow_sticky, 1);
        chk("sat_state", state_o, 2);
        run_to(H_TOT - 1, V_TOT - 1);
        settle();
        chk("frame6_reads_left", exp_q.size(), 0);

        // four consecutive underflows: resync, drain until vertical blank
        clear_mask();
        for (int i = 11; i <= 14; i++) emp_mask[i] = 1'b1;
        emp_mask[20] = 1'b1;
        emp_mask[21] = 1'b1;
        push_frame(0, 14);
        push_drain(15, 39);
        run_to(4, 1);
        settle();
        chk("pre_resync_state", state_o, 2);
        tick();
        settle();
        chk("resync_state", state_o, 3);
        run_to(0, VA);
        settle();
        chk("vbs_state", state_o, 3);
        chk("vbs_rd_en", rd_en, 0);
        tick();
        settle();
        chk("rearm_state", state_o, 1);
        run_to(H_TOT - 1, V_TOT - 1);
        settle();
        chk("frame7_reads_left", exp_q.size(), 0);

        // stream again, then asynchronous reset mid-frame
        clear_mask();
        push_frame(0, 24);
        run_to(0, 0);
        tick();
        settle();
        chk("restream_state", state_o, 2);
        run_to(4, 2);
        tick();
        rst_n = 1'b0;
        settle();
        chk("arst_state", state_o, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_pv", pix_valid, 0);
        chk("arst_mode", sobel_mode, 0);
        chk("arst_thr", thr_o, 0);
        chk("arst_cnt", underflow_cnt, 0);
        chk("arst_sticky", underflow_sticky, 0);
        chk("arst_reads_left", exp_q.size(), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // startup count restarts from zero
        run_to(0, 0);
        tick();
        settle();
        chk("restart_sof1_state", state_o, 0);
        run_to(0, 0);
        tick();
        settle();
        chk("restart_arm_state", state_o, 1);
        @(negedge clk_out);
        #1;
        chk("final_reads_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
